// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Summary  : Shares one SDRAM controller port between video (m0), CPU (m1)
//            and blitter (m2); one single-word transaction at a time.
// Revision : 1.0  initial release
// ============================================================================
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_i,

  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask_i,
  output logic                    m0_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask_i,
  output logic                    m1_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,

  input  logic                    m2_req_i,
  input  logic                    m2_we_i,
  input  logic [ADDR_WIDTH-1:0]   m2_addr_i,
  input  logic [DATA_WIDTH-1:0]   m2_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m2_wmask_i,
  output logic                    m2_ack_o,
  output logic [DATA_WIDTH-1:0]   m2_rdata_o,

  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int         c_MASK_WIDTH   = DATA_WIDTH / 8;
  localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);
  localparam logic [7:0] c_STARVE_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  logic [2:0]            r_grant;      // one-hot, 0 = no grant
  logic                  r_we;
  logic                  r_rr_m2;      // 1: m2 favoured on an m1/m2 tie
  logic [7:0]            r_starve_cnt;
  logic                  r_mem_req;
  logic [2:0]            r_ack;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic [DATA_WIDTH-1:0] r_rdata2;

  logic                  w_others;
  logic                  w_any;
  logic                  w_m0_win;
  logic                  w_pick_m2;
  logic [2:0]            w_win;
  logic                  w_win_we;

  assign w_others  = m1_req_i | m2_req_i;
  assign w_any     = m0_req_i | w_others;
  assign w_m0_win  = m0_req_i & ((r_starve_cnt < c_STARVE_LIMIT) | ~w_others);
  assign w_pick_m2 = m2_req_i & (~m1_req_i | r_rr_m2);

  always_comb begin
    w_win    = 3'b000;
    w_win_we = 1'b0;
    if (w_m0_win) begin
      w_win    = 3'b001;
      w_win_we = m0_we_i;
    end else if (w_pick_m2) begin
      w_win    = 3'b100;
      w_win_we = m2_we_i;
    end else if (m1_req_i) begin
      w_win    = 3'b010;
      w_win_we = m1_we_i;
    end
  end

  // Request fields follow the granted master's live inputs for the whole grant.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = {c_MASK_WIDTH{1'b0}};
    if (r_grant[0]) begin
      mem_we_o    = m0_we_i;
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
      mem_wmask_o = m0_wmask_i;
    end else if (r_grant[1]) begin
      mem_we_o    = m1_we_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_wmask_o = m1_wmask_i;
    end else if (r_grant[2]) begin
      mem_we_o    = m2_we_i;
      mem_addr_o  = m2_addr_i;
      mem_wdata_o = m2_wdata_i;
      mem_wmask_o = m2_wmask_i;
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= S_IDLE;
      r_grant      <= 3'b000;
      r_we         <= 1'b0;
      r_rr_m2      <= 1'b0;
      r_starve_cnt <= 8'd0;
      r_mem_req    <= 1'b0;
      r_ack        <= 3'b000;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_rdata2     <= '0;
    end else begin
      r_ack <= 3'b000;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= w_win;
            r_we      <= w_win_we;
            r_mem_req <= 1'b1;
            r_state   <= S_ISSUE;
            if (w_m0_win) begin
              if (!w_others) begin
                r_starve_cnt <= 8'd0;
              end else if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
              end
            end else begin
              r_starve_cnt <= 8'd0;
              r_rr_m2      <= ~w_pick_m2;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready_i) begin
            r_mem_req <= 1'b0;
            if (r_we) begin
              r_ack   <= r_grant;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT_RD;
            end
          end
        end
        S_WAIT_RD: begin
          if (mem_rvalid_i) begin
            if (r_grant[0]) r_rdata0 <= mem_rdata_i;
            if (r_grant[1]) r_rdata1 <= mem_rdata_i;
            if (r_grant[2]) r_rdata2 <= mem_rdata_i;
            r_ack   <= r_grant;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_grant <= 3'b000;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant   <= 3'b000;
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o  = r_mem_req;
  assign m0_ack_o   = r_ack[0];
  assign m1_ack_o   = r_ack[1];
  assign m2_ack_o   = r_ack[2];
  assign m0_rdata_o = r_rdata0;
  assign m1_rdata_o = r_rdata1;
  assign m2_rdata_o = r_rdata2;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Summary  : Randomised scoreboard bench for sdram_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int SL = 8;

  typedef struct {
    int            m;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    int            iss;
    int            acc;
  } txn_t;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } rd_t;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    d_req = 3'b000;
  logic [2:0]    d_we  = 3'b000;
  logic [AW-1:0] d_addr  [3];
  logic [DW-1:0] d_wdata [3];
  logic [MW-1:0] d_wmask [3];
  logic          mem_ready_i  = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i  = '0;

  logic          m0_ack_o, m1_ack_o, m2_ack_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o, m2_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [MW-1:0] mem_wmask_o;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_i(reset_i),
    .m0_req_i(d_req[0]), .m0_we_i(d_we[0]), .m0_addr_i(d_addr[0]), .m0_wdata_i(d_wdata[0]),
    .m0_wmask_i(d_wmask[0]), .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(d_req[1]), .m1_we_i(d_we[1]), .m1_addr_i(d_addr[1]), .m1_wdata_i(d_wdata[1]),
    .m1_wmask_i(d_wmask[1]), .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o),
    .m2_req_i(d_req[2]), .m2_we_i(d_we[2]), .m2_addr_i(d_addr[2]), .m2_wdata_i(d_wdata[2]),
    .m2_wmask_i(d_wmask[2]), .m2_ack_o(m2_ack_o), .m2_rdata_o(m2_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stimulus controls, owned by the main sequence.
  logic [2:0]    en = 3'b000;
  int            prob = 0;
  logic          spur_en = 1'b0;
  logic          ready_always = 1'b0;
  logic          hold_rvalid = 1'b0;
  int            rv_fixed = 0;
  logic          rd_fixed_en = 1'b0;
  logic [DW-1:0] rd_fixed_val = '0;
  logic [2:0]    os_go = 3'b000;
  logic          os_we = 1'b0;
  logic [AW-1:0] os_addr = '0;
  logic [DW-1:0] os_wdata = '0;
  logic [MW-1:0] os_wmask = '0;
  logic          rec = 1'b0;

  // Reference model and scoreboard state.
  int            starve = 0;
  int            last_rr = 2;
  logic [DW-1:0] exp_rdata [3];
  txn_t          iss_q[$];
  txn_t          ack_q[$];
  rd_t           rd_q[$];
  int            ack_hist[$];
  logic          rd_pending = 1'b0;
  int            rv_timer = 0;
  logic          prev_mreq = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_we = 1'b0;
  int            wait_cnt [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected event or expired bound, required none (cycle %0d)", name, cyc);
  endtask

  // Arbitration rules applied to the requests seen in the cycle before the grant.
  task automatic model_grant();
    int   w;
    logic others;
    txn_t e;
    others = d_req[1] | d_req[2];
    if (d_req == 3'b000) begin
      fail_evt("grant_without_request");
      return;
    end
    if (d_req[0] && (starve < SL || !others)) w = 0;
    else if (d_req[1] && d_req[2])            w = (last_rr == 1) ? 2 : 1;
    else if (d_req[1])                        w = 1;
    else                                      w = 2;
    if (w == 0) starve = others ? ((starve < 255) ? starve + 1 : 255) : 0;
    else begin
      starve  = 0;
      last_rr = w;
    end
    e.m = w; e.we = d_we[w]; e.addr = d_addr[w]; e.wdata = d_wdata[w];
    e.wmask = d_wmask[w]; e.iss = cyc; e.acc = 0;
    iss_q.push_back(e);
  endtask

  // Model, memory responder and master drivers, stepped just after each edge.
  always @(posedge clk) begin
    logic [2:0] a;
    #1;
    if (!reset_i) begin
      d_req = 3'b000;
      iss_q.delete(); ack_q.delete(); rd_q.delete();
      starve = 0; last_rr = 2;
      for (int i = 0; i < 3; i++) begin
        exp_rdata[i] = '0;
        wait_cnt[i]  = 0;
      end
      rd_pending = 1'b0; rv_timer = 0;
      prev_mreq = 1'b0; prev_ready = 1'b0; prev_we = 1'b0;
      mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    end else begin
      cyc++;
      if (mem_req_o && !prev_mreq) model_grant();

      if (prev_mreq && prev_ready && !prev_we) begin
        rd_pending = 1'b1;
        rv_timer   = (rv_fixed > 0) ? rv_fixed - 1 : int'($urandom_range(4));
      end
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (rd_pending && !hold_rvalid) begin
        if (rv_timer == 0) begin
          if (rd_fixed_en) mem_rdata_i = rd_fixed_val;
          mem_rvalid_i = 1'b1;
          rd_q.push_back('{d: mem_rdata_i, c: cyc});
          rd_pending = 1'b0;
        end else begin
          rv_timer--;
        end
      end else if (!rd_pending && spur_en && $urandom_range(7) == 0) begin
        mem_rvalid_i = 1'b1;
      end
      if (mem_req_o) mem_ready_i = ready_always || ($urandom_range(1) == 0);
      else           mem_ready_i = spur_en && ($urandom_range(7) == 0);
      prev_mreq  = mem_req_o;
      prev_ready = mem_ready_i;
      prev_we    = mem_we_o;

      a = {m2_ack_o, m1_ack_o, m0_ack_o};
      for (int m = 0; m < 3; m++) begin
        if (d_req[m] && a[m]) d_req[m] = 1'b0;
        if (!d_req[m]) begin
          wait_cnt[m] = 0;
          if (os_go[m]) begin
            d_req[m] = 1'b1; d_we[m] = os_we; d_addr[m] = os_addr;
            d_wdata[m] = os_wdata; d_wmask[m] = os_wmask; os_go[m] = 1'b0;
          end else if (en[m] && $urandom_range(99) < prob) begin
            d_req[m]   = 1'b1;
            d_we[m]    = 1'($urandom_range(1));
            d_addr[m]  = AW'($urandom);
            d_wdata[m] = $urandom;
            d_wmask[m] = MW'($urandom);
          end
        end else begin
          wait_cnt[m]++;
          if (wait_cnt[m] == 300) fail_evt("request_never_acked");
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT accepts or acknowledges.
  always @(negedge clk) begin
    logic [2:0] ma;
    txn_t       e;
    rd_t        r;
    if (reset_i) begin
      ma = {m2_ack_o, m1_ack_o, m0_ack_o};
      if (mem_req_o && mem_ready_i) begin
        if (iss_q.size() == 0) fail_evt("unexpected_accept");
        else begin
          e = iss_q.pop_front();
          chk("mem_we", 64'(mem_we_o), 64'(e.we));
          chk("mem_addr", 64'(mem_addr_o), 64'(e.addr));
          chk("mem_wdata", 64'(mem_wdata_o), 64'(e.wdata));
          chk("mem_wmask", 64'(mem_wmask_o), 64'(e.wmask));
          e.acc = cyc;
          ack_q.push_back(e);
        end
      end
      if (ma != 3'b000) begin
        chk("single_ack", 64'($countones(ma)), 64'd1);
        if (ack_q.size() == 0) fail_evt("unexpected_ack");
        else begin
          e = ack_q.pop_front();
          chk("ack_master", 64'(ma), 64'(3'b001 << e.m));
          if (e.we) begin
            chk("wr_accept_to_ack", 64'(cyc), 64'(e.acc + 1));
            if (e.acc == e.iss) chk("wr_sample_to_ack", 64'(cyc - (e.iss - 1)), 64'd2);
          end else if (rd_q.size() == 0) begin
            fail_evt("read_ack_without_rvalid");
          end else begin
            r = rd_q.pop_front();
            chk("rd_rvalid_to_ack", 64'(cyc), 64'(r.c + 1));
            exp_rdata[e.m] = r.d;
          end
          if (rec) ack_hist.push_back(e.m);
        end
      end
      chk("m0_rdata", 64'(m0_rdata_o), 64'(exp_rdata[0]));
      chk("m1_rdata", 64'(m1_rdata_o), 64'(exp_rdata[1]));
      chk("m2_rdata", 64'(m2_rdata_o), 64'(exp_rdata[2]));
    end
  end

  task automatic os_fire(input int m, input logic we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    int n = 0;
    @(posedge clk);
    os_we = we; os_addr = ad; os_wdata = wd; os_wmask = wm;
    os_go[m] = 1'b1;
    while (os_go[m] && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) fail_evt("one_shot_not_started");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((d_req != 3'b000 || iss_q.size() != 0 || ack_q.size() != 0 || rd_pending) && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (n >= 600) fail_evt("drain_timeout");
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int run;
    int m1_seen;
    for (int i = 0; i < 3; i++) begin
      d_addr[i] = '0; d_wdata[i] = '0; d_wmask[i] = '0;
      exp_rdata[i] = '0; wait_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_acks", 64'({m2_ack_o, m1_ack_o, m0_ack_o}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_mem_we", 64'(mem_we_o), 64'd0);
    chk("rst_rdata_or", 64'(m0_rdata_o | m1_rdata_o | m2_rdata_o), 64'd0);
    #2 reset_i = 1'b1;

    // Single write on m1, zero-wait acceptance.
    ready_always = 1'b1;
    os_fire(1, 1'b1, 24'h000100, 32'hDEADBEEF, 4'hF);
    wait_idle();
    ready_always = 1'b0;

    // Single read on m2, rvalid four cycles after acceptance.
    rv_fixed = 4; rd_fixed_en = 1'b1; rd_fixed_val = 32'hCAFEF00D;
    os_fire(2, 1'b0, 24'h123456, 32'h0, 4'h0);
    wait_idle();
    rv_fixed = 0; rd_fixed_en = 1'b0;
    chk("directed_m2_rdata", 64'(m2_rdata_o), 64'h00000000CAFEF00D);
    chk("directed_m0_rdata_kept", 64'(m0_rdata_o), 64'd0);
    chk("directed_m1_rdata_kept", 64'(m1_rdata_o), 64'd0);

    // m1 and m2 both requesting continuously must alternate.
    ack_hist.delete(); rec = 1'b1; prob = 100; en = 3'b110;
    repeat (150) @(posedge clk);
    rec = 1'b0; en = 3'b000;
    wait_idle();
    chk("rr_enough_acks", 64'(ack_hist.size() >= 10), 64'd1);
    for (int i = 1; i < ack_hist.size(); i++)
      chk("rr_alternates", 64'(ack_hist[i] != ack_hist[i-1]), 64'd1);

    // m0 and m1 continuously: STARVE_LIMIT m0 grants between m1 grants.
    ack_hist.delete(); rec = 1'b1; en = 3'b011;
    repeat (400) @(posedge clk);
    rec = 1'b0; en = 3'b000;
    wait_idle();
    run = -1; m1_seen = 0;
    foreach (ack_hist[i]) begin
      if (ack_hist[i] == 0) begin
        if (run >= 0) run++;
      end else begin
        if (run >= 0) chk("starve_run_len", 64'(run), 64'(SL));
        run = 0;
        m1_seen++;
      end
    end
    chk("starve_m1_served", 64'(m1_seen >= 3), 64'd1);

    // m0 alone is never limited.
    ack_hist.delete(); rec = 1'b1; en = 3'b001;
    repeat (150) @(posedge clk);
    rec = 1'b0; en = 3'b000;
    wait_idle();
    run = 0;
    foreach (ack_hist[i]) if (ack_hist[i] == 0) run++;
    chk("m0_solo_all_m0", 64'(run), 64'(ack_hist.size()));
    chk("m0_solo_beyond_limit", 64'(run > 2 * SL), 64'd1);

    // Random traffic with spurious ready/rvalid pulses.
    spur_en = 1'b1; en = 3'b111;
    prob = 30;  repeat (3000) @(posedge clk);
    prob = 80;  repeat (3000) @(posedge clk);
    en = 3'b000;
    wait_idle();
    spur_en = 1'b0;

    // Reset while a read is outstanding.
    hold_rvalid = 1'b1;
    os_fire(1, 1'b0, 24'h00ABCD, 32'h0, 4'h0);
    run = 0;
    while (!rd_pending && run < 50) begin
      @(posedge clk);
      run++;
    end
    if (run >= 50) fail_evt("mid_read_not_reached");
    @(negedge clk);
    #2 reset_i = 1'b0;
    #1;
    chk("midrst_mem_req", 64'(mem_req_o), 64'd0);
    chk("midrst_acks", 64'({m2_ack_o, m1_ack_o, m0_ack_o}), 64'd0);
    chk("midrst_rdata_or", 64'(m0_rdata_o | m1_rdata_o | m2_rdata_o), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("midrst_acks_held", 64'({m2_ack_o, m1_ack_o, m0_ack_o}), 64'd0);
    hold_rvalid = 1'b0;
    @(negedge clk);
    #2 reset_i = 1'b1;

    ack_hist.delete(); rec = 1'b1;
    os_fire(1, 1'b1, 24'h000200, 32'h12345678, 4'h3);
    wait_idle();
    rec = 1'b0;
    chk("post_rst_ack_count", 64'(ack_hist.size()), 64'd1);
    if (ack_hist.size() > 0) chk("post_rst_ack_master", 64'(ack_hist[0]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    fail_evt("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller request port between three requesters: video fetch (m0), CPU (m1) and blitter/DMA (m2).
- Sequences one single-word transaction at a time and routes read data back to the requester that issued it.
- m0 has fixed priority, bounded by a starvation limit; m1 and m2 are served round-robin.
- Sits between the xgsoc bus masters and the SDRAM controller, in the clk domain.

Parameters:
- ADDR_WIDTH, 24, word address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- STARVE_LIMIT, 8, maximum consecutive m0 grants while m1 or m2 is pending (range 1..255).

Ports:
- clk  input  1  system clock.
- reset_i  input  1  asynchronous, active-low reset.
- mN_req_i  input  1  request; N = 0, 1, 2. Held high with all fields stable until mN_ack_o.
- mN_we_i  input  1  1 = write, 0 = read.
- mN_addr_i  input  ADDR_WIDTH  word address.
- mN_wdata_i  input  DATA_WIDTH  write data.
- mN_wmask_i  input  DATA_WIDTH/8  byte enables.
- mN_ack_o  output  1  one-cycle completion pulse.
- mN_rdata_o  output  DATA_WIDTH  read data; valid while mN_ack_o is high, held until the next read by the same master.
- mem_req_o  output  1  request to the SDRAM controller.
- mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o  output  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  muxed fields of the granted master.
- mem_ready_i  input  1  controller accepts the request in this cycle.
- mem_rvalid_i  input  1  read data valid.
- mem_rdata_i  input  DATA_WIDTH  read data.

Behaviour:
- Reset (reset_i=0, asynchronous) forces:
  - state to IDLE;
  - all outputs to 0, including mem_req_o and every mN_rdata_o;
  - grant to none, the round-robin pointer to m1 (so m1 is favoured first), and starve_cnt to 0.
- Reset mid-transaction abandons the transaction: no ack is generated.
- The FSM has four states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - If any req_i is high, latch the winner into grant and the winner's we into a register, then go to ISSUE. Otherwise stay in IDLE.
  - Winner selection:
    - m0 wins if m0_req_i is high and either starve_cnt < STARVE_LIMIT or neither m1 nor m2 is requesting.
    - Otherwise the winner is chosen between m1 and m2. If both request, the one not served last wins. If only one requests, it wins.
- ISSUE:
  - mem_req_o=1 and mem_* fields are driven combinationally from the granted master.
  - On mem_ready_i=1: go to DONE for a write, WAIT_RD for a read.
  - mem_req_o falls in the cycle after acceptance.
- WAIT_RD:
  - mem_req_o=0.
  - On mem_rvalid_i=1: register mem_rdata_i into the granted master's rdata_o, then go to DONE.
- DONE:
  - Granted master's ack_o=1 for exactly one cycle, then go to IDLE.
  - A requester that keeps req high is re-arbitrated in the following IDLE cycle; there is no back-to-back grant without passing through IDLE.
- starve_cnt (8 bits, saturating), updated when a grant is latched:
  - m0 granted while m1 or m2 is requesting: increment.
  - m1 or m2 granted: clear to 0.
  - m0 granted with no other requester: clear to 0.
- The round-robin pointer updates only when m1 or m2 is granted.
- Latency from IDLE sampling the request to ack:
  - write: 3 cycles with zero-wait mem_ready_i;
  - read: 3 + (cycles from acceptance to mem_rvalid_i).
- Robustness and boundary rules:
  - mem_ready_i outside ISSUE is ignored.
  - mem_rvalid_i outside WAIT_RD is ignored, and rdata_o is unchanged.
  - A req dropped by a master mid-transaction is a protocol violation. The transaction still completes and ack is still pulsed. The mem_* fields keep following the granted master's inputs.
  - Non-granted masters see ack_o=0 and unchanged rdata_o.
- At most one ack_o is high in any cycle.

Test Plan:
- Reset mid-read (assert reset_i=0 in WAIT_RD, then release) -> all acks stay 0, mem_req_o=0 immediately; a fresh m1 request then completes normally.
- Single write: m1 write, addr=0x000100, wdata=0xDEADBEEF, wmask=0xF, mem_ready_i high on the first ISSUE cycle -> mem_* match exactly; m1_ack_o pulses once, 3 cycles after req is sampled.
- Single read: m2 read, addr=0x123456, mem_rvalid_i 4 cycles after accept with data 0xCAFEF00D -> m2_ack_o pulses once with m2_rdata_o=0xCAFEF00D; m0/m1 rdata unchanged.
- m1 and m2 both holding req continuously -> grant order m1, m2, m1, m2; no m1/m2 ack in consecutive transactions belongs to the same master.
- m0 and m1 requesting continuously, STARVE_LIMIT=8 -> 8 m0 acks, then 1 m1 ack, repeating; with m1 idle, m0 receives unlimited consecutive grants.
- Spurious mem_rvalid_i pulse in IDLE and mem_ready_i pulse in DONE -> no ack, no rdata_o change, FSM sequence unaffected.
